// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet TX framer and its CRC engine:
// the framer state encoding, fixed wire bytes, CRC constants and field sizes.
package eth_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DST,
    ST_SRC,
    ST_VLAN,
    ST_LEN,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } eth_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [15:0] VLAN_TPID     = 16'h8100;

  localparam int MAC_BYTES  = 6;
  localparam int LEN_BYTES  = 2;
  localparam int VLAN_BYTES = 4;
  localparam int FCS_BYTES  = 4;

  // One byte step of the reflected CRC-32, LSB of the data entering first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Registered byte-wise reflected CRC-32. Shared between the TX framer and
// the RX checker, so it knows nothing about frame structure: clr reloads the
// seed, en folds one byte in, and the running remainder is always visible.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;

  // Remainder register: clear has priority over a data update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc <= CRC_INIT;
    end else if (i_clr) begin
      r_crc <= CRC_INIT;
    end else if (i_en) begin
      r_crc <= crc32_byte(r_crc, i_data);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/eth_tx_framer.sv
// Streaming Ethernet TX framer: wraps a byte-streamed payload in preamble,
// SFD, addresses, length, zero padding and FCS, then holds off for the IFG.
// No frame buffer: payload bytes pass straight from s_data to txd.
// Optional 802.1Q tag insertion is built when ETH_TX_VLAN_EN is defined.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter logic [47:0] DST_MAC      = 48'h023528fbdd66,
  parameter logic [47:0] SRC_MAC      = 48'h072227acdb65,
  parameter int          PREAMBLE_LEN = 7,
  parameter int          MIN_PAYLOAD  = 46,
  parameter int          MAX_PAYLOAD  = 1500,
  parameter int          IFG_LEN      = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hdr_valid,
  output logic        o_hdr_ready,
  input  logic [15:0] i_hdr_len,
  input  logic [15:0] i_hdr_tci,
  input  logic [7:0]  i_s_data,
  input  logic        i_s_valid,
  output logic        o_s_ready,
  input  logic        i_s_last,
  output logic [7:0]  o_txd,
  output logic        o_tx_en,
  output logic        o_tx_er,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_err_len
);

`ifdef ETH_TX_VLAN_EN
  // The tag counts toward the minimum frame size, so less padding is needed.
  localparam int MIN_EFF = MIN_PAYLOAD - VLAN_BYTES;
  localparam logic [15:0] L_VLAN_LAST = 16'(VLAN_BYTES - 1);
`else
  localparam int MIN_EFF = MIN_PAYLOAD;
`endif
  localparam logic [15:0] L_PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] L_MAC_LAST = 16'(MAC_BYTES - 1);
  localparam logic [15:0] L_LEN_LAST = 16'(LEN_BYTES - 1);
  localparam logic [15:0] L_FCS_LAST = 16'(FCS_BYTES - 1);
  localparam logic [15:0] L_IFG_LAST = 16'(IFG_LEN - 1);
  localparam logic [15:0] L_MIN_EFF  = 16'(MIN_EFF);
  localparam logic [15:0] L_MAX_PAY  = 16'(MAX_PAYLOAD);

  eth_state_t  r_state, w_next_state;
  logic [15:0] r_count, w_next_count;
  logic [15:0] r_len;
  logic        w_latch;

  logic [7:0]  w_txd;
  logic        w_tx_en, w_tx_er, w_frame_done, w_err_len;
  logic        w_crc_clr, w_crc_en;
  logic [31:0] w_crc, w_fcs, w_fcs_shift;
  logic        w_last_pos, w_pad_last;

  logic [7:0]  r_txd;
  logic        r_tx_en, r_tx_er, r_busy, r_frame_done, r_err_len;

`ifdef ETH_TX_VLAN_EN
  logic [15:0] r_tci;
`else
  logic        w_unused_tci;
  assign w_unused_tci = ^i_hdr_tci;
`endif

  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [15:0] idx);
    logic [47:0] sh;
    sh = mac << {idx[2:0], 3'b000};
    return sh[47:40];
  endfunction

  eth_crc32 u_crc (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_crc_clr),
    .i_en   (w_crc_en),
    .i_data (w_txd),
    .o_crc  (w_crc)
  );

  assign w_fcs       = ~w_crc;
  assign w_fcs_shift = w_fcs >> {r_count[1:0], 3'b000};
  assign w_last_pos  = (r_count == r_len - 16'd1);
  assign w_pad_last  = (r_count == L_MIN_EFF - r_len - 16'd1);

  assign o_hdr_ready = (r_state == ST_IDLE);
  assign o_s_ready   = (r_state == ST_PAYLOAD);

  // State, per-state byte counter and latched header fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= 16'd0;
      r_len   <= 16'd0;
`ifdef ETH_TX_VLAN_EN
      r_tci   <= 16'd0;
`endif
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
      if (w_latch) begin
        r_len <= i_hdr_len;
`ifdef ETH_TX_VLAN_EN
        r_tci <= i_hdr_tci;
`endif
      end
    end
  end

  // Next state plus the wire byte for the current state; the byte is
  // registered below, so txd always trails the state by one cycle.
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count + 16'd1;
    w_latch      = 1'b0;
    w_txd        = 8'h00;
    w_tx_en      = 1'b0;
    w_tx_er      = 1'b0;
    w_frame_done = 1'b0;
    w_err_len    = 1'b0;
    w_crc_clr    = 1'b0;
    w_crc_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_count = 16'd0;
        if (i_hdr_valid) begin
          if (i_hdr_len == 16'd0 || i_hdr_len > L_MAX_PAY) begin
            w_err_len = 1'b1;
          end else begin
            w_latch      = 1'b1;
            w_next_state = ST_PREAMBLE;
          end
        end
      end
      ST_PREAMBLE: begin
        w_txd     = PREAMBLE_BYTE;
        w_tx_en   = 1'b1;
        w_crc_clr = 1'b1;
        if (r_count == L_PRE_LAST) begin
          w_next_state = ST_SFD;
          w_next_count = 16'd0;
        end
      end
      ST_SFD: begin
        w_txd        = SFD_BYTE;
        w_tx_en      = 1'b1;
        w_crc_clr    = 1'b1;
        w_next_state = ST_DST;
        w_next_count = 16'd0;
      end
      ST_DST: begin
        w_txd    = mac_byte(DST_MAC, r_count);
        w_tx_en  = 1'b1;
        w_crc_en = 1'b1;
        if (r_count == L_MAC_LAST) begin
          w_next_state = ST_SRC;
          w_next_count = 16'd0;
        end
      end
      ST_SRC: begin
        w_txd    = mac_byte(SRC_MAC, r_count);
        w_tx_en  = 1'b1;
        w_crc_en = 1'b1;
        if (r_count == L_MAC_LAST) begin
`ifdef ETH_TX_VLAN_EN
          w_next_state = ST_VLAN;
`else
          w_next_state = ST_LEN;
`endif
          w_next_count = 16'd0;
        end
      end
`ifdef ETH_TX_VLAN_EN
      ST_VLAN: begin
        w_tx_en  = 1'b1;
        w_crc_en = 1'b1;
        case (r_count[1:0])
          2'd0:    w_txd = VLAN_TPID[15:8];
          2'd1:    w_txd = VLAN_TPID[7:0];
          2'd2:    w_txd = r_tci[15:8];
          default: w_txd = r_tci[7:0];
        endcase
        if (r_count == L_VLAN_LAST) begin
          w_next_state = ST_LEN;
          w_next_count = 16'd0;
        end
      end
`endif
      ST_LEN: begin
        w_txd    = (r_count == 16'd0) ? r_len[15:8] : r_len[7:0];
        w_tx_en  = 1'b1;
        w_crc_en = 1'b1;
        if (r_count == L_LEN_LAST) begin
          w_next_state = ST_PAYLOAD;
          w_next_count = 16'd0;
        end
      end
      ST_PAYLOAD: begin
        w_tx_en = 1'b1;
        if (!i_s_valid) begin
          w_tx_er      = 1'b1;
          w_next_state = ST_IFG;
          w_next_count = 16'd0;
        end else begin
          w_txd    = i_s_data;
          w_crc_en = 1'b1;
          if (i_s_last != w_last_pos) begin
            w_tx_er      = 1'b1;
            w_err_len    = 1'b1;
            w_next_state = ST_IFG;
            w_next_count = 16'd0;
          end else if (w_last_pos) begin
            w_next_state = (r_len < L_MIN_EFF) ? ST_PAD : ST_FCS;
            w_next_count = 16'd0;
          end
        end
      end
      ST_PAD: begin
        w_tx_en  = 1'b1;
        w_crc_en = 1'b1;
        if (w_pad_last) begin
          w_next_state = ST_FCS;
          w_next_count = 16'd0;
        end
      end
      ST_FCS: begin
        w_txd   = w_fcs_shift[7:0];
        w_tx_en = 1'b1;
        if (r_count == L_FCS_LAST) begin
          w_frame_done = 1'b1;
          w_next_state = ST_IFG;
          w_next_count = 16'd0;
        end
      end
      ST_IFG: begin
        if (r_count == L_IFG_LAST) begin
          w_next_state = ST_IDLE;
          w_next_count = 16'd0;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_count = 16'd0;
      end
    endcase
  end

  // Registered GMII side and status pulses; busy follows the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txd        <= 8'h00;
      r_tx_en      <= 1'b0;
      r_tx_er      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_len    <= 1'b0;
    end else begin
      r_txd        <= w_txd;
      r_tx_en      <= w_tx_en;
      r_tx_er      <= w_tx_er;
      r_busy       <= (w_next_state != ST_IDLE);
      r_frame_done <= w_frame_done;
      r_err_len    <= w_err_len;
    end
  end

  assign o_txd        = r_txd;
  assign o_tx_en      = r_tx_en;
  assign o_tx_er      = r_tx_er;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_err_len    = r_err_len;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Randomised bench for eth_tx_framer: each frame on the wire is collected
// and compared with a frame assembled from the Ethernet framing rules.
module tb_eth_tx_framer;

  localparam int PRE_LEN = 7;
  localparam int MAX_PAY = 1500;
  localparam int IFG     = 12;
  localparam logic [47:0] DST = 48'h023528fbdd66;
  localparam logic [47:0] SRC = 48'h072227acdb65;
`ifdef ETH_TX_VLAN_EN
  localparam bit VLAN    = 1'b1;
  localparam int MIN_EFF = 42;
`else
  localparam bit VLAN    = 1'b0;
  localparam int MIN_EFF = 46;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_hdr_valid = 1'b0, i_s_valid = 1'b0, i_s_last = 1'b0;
  logic [15:0] i_hdr_len = 16'd0, i_hdr_tci = 16'd0;
  logic [7:0]  i_s_data = 8'd0;
  logic o_hdr_ready, o_s_ready, o_tx_en, o_tx_er, o_busy, o_frame_done, o_err_len;
  logic [7:0] o_txd;

  logic crcClr = 1'b0, crcEn = 1'b0;
  logic [7:0] crcData = 8'd0;
  logic [31:0] crcOut;

  always #5 clk = ~clk;

  eth_tx_framer dut (
    .clk(clk), .rst(rst),
    .i_hdr_valid(i_hdr_valid), .o_hdr_ready(o_hdr_ready),
    .i_hdr_len(i_hdr_len), .i_hdr_tci(i_hdr_tci),
    .i_s_data(i_s_data), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_last(i_s_last),
    .o_txd(o_txd), .o_tx_en(o_tx_en), .o_tx_er(o_tx_er),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err_len(o_err_len)
  );

  eth_crc32 crcUnit (
    .clk(clk), .rst(rst), .i_clr(crcClr), .i_en(crcEn), .i_data(crcData), .o_crc(crcOut)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] pay [0:MAX_PAY-1];
  logic [7:0] expQ [$];

  logic [7:0] byteQ [$];
  bit         erQ [$];
  int cyc = 0, lastEn = 0, readyRise = 0, fdIdx = -1, fdCount = 0, errCount = 0;
  bit prevReady = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wire monitor: records every tx_en byte and the timing of status pulses.
  always @(negedge clk) begin
    cyc++;
    if (o_tx_en) begin
      byteQ.push_back(o_txd);
      erQ.push_back(o_tx_er);
      lastEn = cyc;
    end
    if (o_frame_done) begin
      fdCount++;
      fdIdx = byteQ.size() - 1;
    end
    if (o_err_len) errCount++;
    if (o_hdr_ready && !prevReady) readyRise = cyc;
    prevReady = o_hdr_ready;
  end

  task automatic clearMon();
    byteQ.delete();
    erQ.delete();
    fdIdx = -1;
    fdCount = 0;
    errCount = 0;
    lastEn = 0;
    readyRise = 0;
  endtask

  function automatic logic [31:0] crcOf(input logic [7:0] q[$]);
    logic [31:0] c;
    bit fb;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  // Expected wire bytes; cut >= 0 means the frame stops after cut payload bytes.
  function automatic void buildExpected(input int len, input int cut, input logic [15:0] tci);
    logic [7:0] body [$];
    logic [47:0] d, s;
    logic [15:0] lv;
    logic [31:0] fcs;
    int n;
    d = DST;
    s = SRC;
    lv = 16'(len);
    expQ.delete();
    for (int i = 0; i < PRE_LEN; i++) expQ.push_back(8'h55);
    expQ.push_back(8'hD5);
    for (int i = 0; i < 6; i++) body.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) body.push_back(s[47-8*i -: 8]);
    if (VLAN) begin
      body.push_back(8'h81);
      body.push_back(8'h00);
      body.push_back(tci[15:8]);
      body.push_back(tci[7:0]);
    end
    body.push_back(lv[15:8]);
    body.push_back(lv[7:0]);
    n = (cut < 0) ? len : cut;
    for (int i = 0; i < n; i++) body.push_back(pay[i]);
    if (cut < 0) begin
      for (int i = len; i < MIN_EFF; i++) body.push_back(8'h00);
      fcs = ~crcOf(body);
      for (int b = 0; b < 4; b++) body.push_back(fcs[8*b +: 8]);
    end
    foreach (body[i]) expQ.push_back(body[i]);
  endfunction

  // mode: 0 good frame, 1 underrun at byte k, 2 early s_last at byte k,
  // 3 s_last never given, 4 header that must be rejected.
  task automatic applyStimulus(input int len, input int mode, input int k,
                               input logic [15:0] tci, input bit ramp);
    int idx, guard, erCnt, total, cut;
    bit done, abort;
    for (int i = 0; i < MAX_PAY; i++) pay[i] = ramp ? 8'(i) : 8'($urandom);
    clearMon();
    i_hdr_valid = 1'b1;
    i_hdr_len   = 16'(len);
    i_hdr_tci   = tci;
    @(negedge clk);
    i_hdr_valid = 1'b0;
    i_hdr_len   = 16'($urandom);
    i_hdr_tci   = 16'($urandom);
    if (mode == 4) begin
      repeat (3) @(negedge clk);
      checkOutput("rejErr", errCount, 1);
      checkOutput("rejTxEn", byteQ.size(), 0);
      checkOutput("rejReady", o_hdr_ready, 1);
      checkOutput("rejBusy", o_busy, 0);
      return;
    end
    checkOutput("busy", o_busy, 1);
    idx = 0;
    guard = 0;
    done = 1'b0;
    while (!done && guard < 3000) begin
      i_s_valid = 1'b1;
      i_s_data  = pay[idx];
      i_s_last  = (mode == 0 && idx == len - 1) || (mode == 2 && idx == k);
      if (mode == 1 && idx == k) i_s_valid = 1'b0;
      if (o_s_ready) begin
        if (mode == 1 && idx == k) done = 1'b1;
        else begin
          if ((mode == 2 && idx == k) || idx == len - 1) done = 1'b1;
          idx++;
        end
      end
      @(negedge clk);
      guard++;
    end
    i_s_valid = 1'b0;
    i_s_last  = 1'b0;
    checkOutput("drvDone", done, 1);
    guard = 0;
    while (!o_hdr_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("readyWait", o_hdr_ready, 1);
    @(negedge clk);
    checkOutput("busyEnd", o_busy, 0);
    abort = (mode != 0);
    cut = (mode == 0) ? -1 : (mode == 3) ? len - 1 : k;
    buildExpected(len, cut, tci);
    total = expQ.size() + (abort ? 1 : 0);
    checkOutput("frameLen", byteQ.size(), total);
    for (int i = 0; i < expQ.size() && i < byteQ.size(); i++)
      checkOutput($sformatf("byte%0d", i), byteQ[i], expQ[i]);
    erCnt = 0;
    foreach (erQ[i]) erCnt += erQ[i];
    checkOutput("erCount", erCnt, abort ? 1 : 0);
    if (abort && erQ.size() > 0) checkOutput("erLast", erQ[$], 1);
    checkOutput("doneCount", fdCount, abort ? 0 : 1);
    if (!abort) checkOutput("doneIdx", fdIdx, total - 1);
    checkOutput("errLen", errCount, (mode == 2 || mode == 3) ? 1 : 0);
    checkOutput("ifg", readyRise - lastEn, IFG);
  endtask

  initial begin
    string digits;
    int idx, guard;
    digits = "123456789";
    repeat (3) @(negedge clk);
    checkOutput("rstTxd", o_txd, 0);
    checkOutput("rstTxEn", o_tx_en, 0);
    checkOutput("rstTxEr", o_tx_er, 0);
    checkOutput("rstBusy", o_busy, 0);
    checkOutput("rstDone", o_frame_done, 0);
    checkOutput("rstErr", o_err_len, 0);
    checkOutput("rstSReady", o_s_ready, 0);
    checkOutput("rstHdrReady", o_hdr_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    crcClr = 1'b1;
    @(negedge clk);
    crcClr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      crcEn = 1'b1;
      crcData = digits[i];
      @(negedge clk);
    end
    crcEn = 1'b0;
    checkOutput("crcCheck", ~crcOut, 32'hCBF43926);

    applyStimulus(64, 0, 0, 16'h2005, 1'b1);
    applyStimulus(10, 0, 0, 16'h2005, 1'b0);
    applyStimulus(1, 0, 0, 16'($urandom), 1'b0);
    applyStimulus(MIN_EFF, 0, 0, 16'($urandom), 1'b0);
    for (int f = 0; f < 6; f++)
      applyStimulus($urandom_range(1, 120), 0, 0, 16'($urandom), 1'b0);
    applyStimulus(30, 1, 5, 16'($urandom), 1'b0);
    applyStimulus(1501, 4, 0, 16'($urandom), 1'b0);
    applyStimulus(0, 4, 0, 16'($urandom), 1'b0);
    applyStimulus(20, 2, 18, 16'($urandom), 1'b0);
    applyStimulus($urandom_range(5, 80), 3, 0, 16'($urandom), 1'b0);
    applyStimulus(MAX_PAY, 0, 0, 16'($urandom), 1'b0);

    // Reset in the middle of the payload, then a clean frame afterwards.
    clearMon();
    i_hdr_valid = 1'b1;
    i_hdr_len = 16'd60;
    @(negedge clk);
    i_hdr_valid = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < 10 && guard < 200) begin
      i_s_valid = 1'b1;
      i_s_data = 8'(idx);
      if (o_s_ready) idx++;
      @(negedge clk);
      guard++;
    end
    checkOutput("midDrv", idx, 10);
    rst = 1'b1;
    #1;
    checkOutput("midTxEn", o_tx_en, 0);
    checkOutput("midSReady", o_s_ready, 0);
    checkOutput("midBusy", o_busy, 0);
    i_s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midHdrReady", o_hdr_ready, 1);
    clearMon();
    repeat (20) @(negedge clk);
    checkOutput("noResume", byteQ.size(), 0);
    applyStimulus(50, 0, 0, 16'($urandom), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
